// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states and lane helpers.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } memState_e;

  // Reserved size 11 behaves as a word everywhere.
  function automatic logic isAligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lane[0];
      default: return lane == 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byteEnables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] storeData(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide request/acknowledge memory bus between the access unit and the data memory.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rawData,
  input  logic [1:0]  addrLow,
  input  logic [1:0]  size,
  input  logic        isSigned,
  output logic [31:0] extData
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  always_comb begin
    byteVal = rawData[{addrLow, 3'b000} +: 8];
    halfVal = addrLow[1] ? rawData[31:16] : rawData[15:0];
    case (size)
      SZ_BYTE: extData = {{24{isSigned & byteVal[7]}}, byteVal};
      SZ_HALF: extData = {{16{isSigned & halfVal[15]}}, halfVal};
      default: extData = rawData;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: IDLE/WAIT/DONE handshake with a word-wide memory, stalling the pipeline.
// Optional access timeout with bus error is built when MEM_TIMEOUT_EN is defined.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [31:0]              ALUResult_MEM,
  input  logic [31:0]              WriteData_MEM,
  input  logic                     MemRead_MEM,
  input  logic                     MemWrite_MEM,
  input  logic [1:0]               MemSize_MEM,
  input  logic                     MemSigned_MEM,
  mem_access_unit_if.master        memBus,
  output logic [31:0]              ReadDataFromMem_MEM,
  output logic                     Stall_MEM,
  output logic                     AddrErr_MEM,
  output logic                     BusErr_MEM
);

  memState_e   state_q, state_d;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q, rdData_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q, lane_q;
  logic        signed_q, addrErr_q;
  logic        startAccess, finishAccess, timeout, misaligned, stall, timeoutHit;
  logic [31:0] extData;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] waitCnt_q;
  logic            busErr_q;

  assign timeoutHit = (waitCnt_q == CntW'(TIMEOUT_CYC - 1));
  assign BusErr_MEM = busErr_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      waitCnt_q <= '0;
      busErr_q  <= 1'b0;
    end else begin
      busErr_q  <= timeout;
      waitCnt_q <= (state_q == WAIT && !finishAccess && !timeout) ? waitCnt_q + CntW'(1) : '0;
    end
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYC;
  assign timeoutHit    = 1'b0;
  assign BusErr_MEM    = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    startAccess  = 1'b0;
    finishAccess = 1'b0;
    timeout      = 1'b0;
    misaligned   = 1'b0;
    stall        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemRead_MEM || MemWrite_MEM) begin
          if (isAligned(MemSize_MEM, ALUResult_MEM[1:0])) begin
            startAccess = 1'b1;
            stall       = 1'b1;
            state_d     = WAIT;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (memBus.mem_ack) begin
          finishAccess = 1'b1;
          state_d      = DONE;
        end else if (timeoutHit) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  load_extend uLoadExtend (
    .rawData  (memBus.mem_rdata),
    .addrLow  (lane_q),
    .size     (size_q),
    .isSigned (signed_q),
    .extData  (extData)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      size_q    <= SZ_WORD;
      lane_q    <= '0;
      signed_q  <= 1'b0;
      rdData_q  <= '0;
      addrErr_q <= 1'b0;
    end else begin
      addrErr_q <= misaligned;
      if (startAccess) begin
        req_q    <= 1'b1;
        we_q     <= MemWrite_MEM;
        addr_q   <= {ALUResult_MEM[31:2], 2'b00};
        wdata_q  <= storeData(MemSize_MEM, WriteData_MEM);
        be_q     <= byteEnables(MemSize_MEM, ALUResult_MEM[1:0]);
        size_q   <= MemSize_MEM;
        lane_q   <= ALUResult_MEM[1:0];
        signed_q <= MemSigned_MEM;
      end else if (finishAccess || timeout) begin
        req_q <= 1'b0;
        we_q  <= 1'b0;
        be_q  <= '0;
        if (finishAccess && !we_q) rdData_q <= extData;
      end
    end
  end

  assign memBus.mem_req    = req_q;
  assign memBus.mem_we     = we_q;
  assign memBus.mem_addr   = addr_q;
  assign memBus.mem_wdata  = wdata_q;
  assign memBus.mem_be     = be_q;
  assign ReadDataFromMem_MEM = rdData_q;
  assign AddrErr_MEM       = addrErr_q;
  assign Stall_MEM         = stall & ~Reset;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: bench acts as the memory, expectations go through a scoreboard.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        Clk, Reset;
  logic [31:0] ALUResult_MEM, WriteData_MEM;
  logic        MemRead_MEM, MemWrite_MEM, MemSigned_MEM;
  logic [1:0]  MemSize_MEM;
  logic [31:0] ReadDataFromMem_MEM;
  logic        Stall_MEM, AddrErr_MEM, BusErr_MEM;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYC(4)) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .ALUResult_MEM       (ALUResult_MEM),
    .WriteData_MEM       (WriteData_MEM),
    .MemRead_MEM         (MemRead_MEM),
    .MemWrite_MEM        (MemWrite_MEM),
    .MemSize_MEM         (MemSize_MEM),
    .MemSigned_MEM       (MemSigned_MEM),
    .memBus              (bus),
    .ReadDataFromMem_MEM (ReadDataFromMem_MEM),
    .Stall_MEM           (Stall_MEM),
    .AddrErr_MEM         (AddrErr_MEM),
    .BusErr_MEM          (BusErr_MEM)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] rd;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] modelRd;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dropInputs();
    MemRead_MEM  = 1'b0;
    MemWrite_MEM = 1'b0;
  endtask

  // ackAt: WAIT cycle (1-based) on which the memory acks; 0 means never ack.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int ackAt, input logic [3:0] expBe,
                        input logic [31:0] expWdata, input logic [31:0] expLoad);
    exp_t e;
    int   stalls, waits, expStalls;
    bit   done;
    e.addr  = {addr[31:2], 2'b00};
    e.wdata = expWdata;
    e.be    = expBe;
    e.we    = wr;
    if (!wr && ackAt != 0) modelRd = expLoad;
    e.rd = modelRd;
    sbQ.push_back(e);
    expStalls = 1 + ((ackAt == 0) ? 4 : ackAt);

    @(posedge Clk); #1;
    ALUResult_MEM = addr;  WriteData_MEM = wdata;  MemRead_MEM = rd;  MemWrite_MEM = wr;
    MemSize_MEM   = size;  MemSigned_MEM = sgn;
    #1;
    check({tag, " idle stall"}, 32'(Stall_MEM), 32'd1);
    check({tag, " idle req"}, 32'(bus.mem_req), 32'd0);
    stalls = 1;
    waits  = 0;
    done   = 1'b0;
    e      = sbQ.pop_front();
    for (int c = 0; c < 50; c++) begin
      @(posedge Clk); #1;
      bus.mem_ack   = (ackAt != 0) && (waits + 1 == ackAt);
      bus.mem_rdata = bus.mem_ack ? rdata : $urandom;
      #1;
      if (!Stall_MEM) begin
        done = 1'b1;
        break;
      end
      stalls++;
      waits++;
      check({tag, " wait req"}, 32'(bus.mem_req), 32'd1);
      check({tag, " wait we"}, 32'(bus.mem_we), 32'(e.we));
      check({tag, " wait addr"}, bus.mem_addr, e.addr);
      check({tag, " wait wdata"}, bus.mem_wdata, e.wdata);
      check({tag, " wait be"}, 32'(bus.mem_be), 32'(e.be));
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL %s: stall never released, observed=1 expected=0", tag);
    end
    check({tag, " stall cycles"}, 32'(stalls), 32'(expStalls));
    check({tag, " done req"}, 32'(bus.mem_req), 32'd0);
    check({tag, " done be"}, 32'(bus.mem_be), 32'd0);
    check({tag, " done rdata"}, ReadDataFromMem_MEM, e.rd);
    check({tag, " done buserr"}, 32'(BusErr_MEM), 32'(ackAt == 0));
    dropInputs();
    // A stray ack outside WAIT must not be captured.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5A5A_A5A5;
    @(posedge Clk); #1;
    bus.mem_ack = 1'b0;
    #1;
    check({tag, " after rdata"}, ReadDataFromMem_MEM, e.rd);
    check({tag, " after req"}, 32'(bus.mem_req), 32'd0);
    check({tag, " after buserr"}, 32'(BusErr_MEM), 32'd0);
  endtask

  task automatic misalignedAccess(input string tag, input logic [1:0] size, input logic [31:0] addr);
    @(posedge Clk); #1;
    ALUResult_MEM = addr;  MemSize_MEM = size;  MemRead_MEM = 1'b1;  MemWrite_MEM = 1'b0;
    #1;
    check({tag, " stall"}, 32'(Stall_MEM), 32'd0);
    @(posedge Clk); #1;
    dropInputs();
    #1;
    check({tag, " addrerr pulse"}, 32'(AddrErr_MEM), 32'd1);
    check({tag, " req"}, 32'(bus.mem_req), 32'd0);
    check({tag, " stall2"}, 32'(Stall_MEM), 32'd0);
    @(posedge Clk); #2;
    check({tag, " addrerr clear"}, 32'(AddrErr_MEM), 32'd0);
    check({tag, " rdata kept"}, ReadDataFromMem_MEM, modelRd);
  endtask

  initial begin
    Reset = 1'b1;
    ALUResult_MEM = '0;  WriteData_MEM = '0;  MemSize_MEM = SZ_WORD;  MemSigned_MEM = 1'b0;
    MemRead_MEM = 1'b1;  MemWrite_MEM = 1'b0;
    bus.mem_ack = 1'b0;  bus.mem_rdata = '0;
    modelRd = '0;
    #2;
    check("reset stall", 32'(Stall_MEM), 32'd0);
    check("reset req", 32'(bus.mem_req), 32'd0);
    check("reset be", 32'(bus.mem_be), 32'd0);
    check("reset rdata", ReadDataFromMem_MEM, 32'd0);
    check("reset addrerr", 32'(AddrErr_MEM), 32'd0);
    check("reset buserr", 32'(BusErr_MEM), 32'd0);
    @(posedge Clk); #1;
    dropInputs();
    Reset = 1'b0;

    access("word store", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,
           2, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    access("lb signed", 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h0000_0003, 32'h0, 32'h80FF_FF7F,
           1, 4'b1000, 32'h0, 32'hFFFF_FF80);
    access("lbu", 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0003, 32'h0, 32'h80FF_FF7F,
           3, 4'b1000, 32'h0, 32'h0000_0080);
    access("half store", 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h0000_0006, 32'h5555_1234, 32'h0,
           2, 4'b1100, 32'h1234_1234, 32'h0);
    access("byte store", 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'h0,
           1, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    access("lh signed", 1'b1, 1'b0, SZ_HALF, 1'b1, 32'h0000_0002, 32'h0, 32'h8001_1234,
           1, 4'b1100, 32'h0, 32'hFFFF_8001);
    access("lhu low", 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h0000_0100, 32'h0, 32'h8001_F234,
           2, 4'b0011, 32'h0, 32'h0000_F234);
    access("rd+wr", 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 32'h1111_2222,
           1, 4'b1111, 32'hCAFE_F00D, 32'h0);

    misalignedAccess("lw misaligned", SZ_WORD, 32'h0000_0002);
    misalignedAccess("lh misaligned", SZ_HALF, 32'h0000_0001);

`ifdef MEM_TIMEOUT_EN
    access("timeout", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0020, 32'h0, 32'h0,
           0, 4'b1111, 32'h0, 32'h0);
`endif

    // Reset in the middle of WAIT, followed by a stray ack.
    @(posedge Clk); #1;
    ALUResult_MEM = 32'h0000_000C;  MemSize_MEM = SZ_WORD;  MemRead_MEM = 1'b1;
    @(posedge Clk); #1;
    check("rstwait req", 32'(bus.mem_req), 32'd1);
    Reset = 1'b1;
    #1;
    modelRd = '0;
    check("rstwait req0", 32'(bus.mem_req), 32'd0);
    check("rstwait stall", 32'(Stall_MEM), 32'd0);
    check("rstwait addr", bus.mem_addr, 32'd0);
    check("rstwait be", 32'(bus.mem_be), 32'd0);
    check("rstwait rdata", ReadDataFromMem_MEM, modelRd);
    check("rstwait state", 32'(dut.state_q), 32'(IDLE));
    @(posedge Clk); #1;
    Reset = 1'b0;
    dropInputs();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge Clk); #1;
    bus.mem_ack = 1'b0;
    #1;
    check("stray ack rdata", ReadDataFromMem_MEM, modelRd);
    check("stray ack req", 32'(bus.mem_req), 32'd0);
    check("stray ack stall", 32'(Stall_MEM), 32'd0);
    check("stray ack state", 32'(dut.state_q), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16: the maximum number of WAIT cycles before a bus error (used only when MEM_TIMEOUT_EN is defined).
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port ALUResult_MEM, input, 32 bits: the effective byte address from the EX/MEM register.
REQ-005 SHALL have port WriteData_MEM, input, 32 bits: the store data, right-justified.
REQ-006 SHALL have port MemRead_MEM, input, 1 bit: load request.
REQ-007 SHALL have port MemWrite_MEM, input, 1 bit: store request.
REQ-008 SHALL have port MemSize_MEM, input, 2 bits: access size; 00 = word, 01 = half, 10 = byte, 11 = reserved (treated as word).
REQ-009 SHALL have port MemSigned_MEM, input, 1 bit: 1 = sign-extend the load, 0 = zero-extend.
REQ-010 SHALL have port mem_ack, input, 1 bit: the memory completes the access in this cycle.
REQ-011 SHALL have port mem_rdata, input, 32 bits: read data, valid while mem_ack = 1.
REQ-012 SHALL have port mem_req, output, 1 bit: access outstanding.
REQ-013 SHALL have port mem_we, output, 1 bit: 1 = write access.
REQ-014 SHALL have port mem_addr, output, 32 bits: word-aligned address ({addr[31:2], 2'b00}).
REQ-015 SHALL have port mem_wdata, output, 32 bits: store data replicated onto the selected byte lanes.
REQ-016 SHALL have port mem_be, output, 4 bits: byte enables.
REQ-017 SHALL have port ReadDataFromMem_MEM, output, 32 bits: the extended load result, fed to MEM/WB.
REQ-018 SHALL have port Stall_MEM, output, 1 bit: freeze the PC and the IF/ID, ID/EX and EX/MEM registers, and hold MEM/WB.
REQ-019 SHALL have port AddrErr_MEM, output, 1 bit: one-cycle pulse on a misaligned access.
REQ-020 SHALL have port BusErr_MEM, output, 1 bit: one-cycle pulse on an access timeout.

Function
REQ-021 SHALL implement a registered FSM with states IDLE, WAIT and DONE.
REQ-022 SHALL, in IDLE with (MemRead_MEM | MemWrite_MEM) and an aligned address, assert Stall_MEM combinationally, register mem_req = 1, latch the address, data, BE, size and signed controls, and move to WAIT.
REQ-023 SHALL define alignment as: half requires addr[0] = 0; word requires addr[1:0] = 00; byte is always aligned.
REQ-024 SHALL, on a misaligned access in IDLE, pulse AddrErr_MEM for 1 cycle, issue no request, leave Stall_MEM low, and leave ReadDataFromMem_MEM unchanged.
REQ-025 SHALL treat MemRead_MEM and MemWrite_MEM both asserted as a write; ReadDataFromMem_MEM is not updated.
REQ-026 SHALL, in WAIT, hold mem_req, mem_we, mem_addr, mem_wdata and mem_be stable and Stall_MEM = 1 until mem_ack is seen.
REQ-027 SHALL, on mem_ack in WAIT, drop mem_req on the next edge, capture the extended mem_rdata (for a load) into ReadDataFromMem_MEM, and move to DONE.
REQ-028 SHALL hold Stall_MEM = 0 in DONE for exactly 1 cycle so the pipeline advances, then return to IDLE; this gives a minimum access latency of 3 cycles (IDLE, WAIT, DONE).
REQ-029 SHALL ignore mem_ack outside WAIT.
REQ-030 SHALL use little-endian lanes: byte at addr[1:0] = n → be = 1 << n, data on bits 8n+7:8n; half at addr[1] = h → be = 0011 << 2h.
REQ-031 SHALL form mem_wdata as the byte replicated ×4 for byte stores, the half replicated ×2 for half stores, and the word unchanged for word stores.
REQ-032 SHALL, for loads, select the addressed lane and sign-extend (MemSigned_MEM = 1) or zero-extend to 32 bits; word loads pass through unchanged.
REQ-033 SHALL keep mem_be = 0000 whenever mem_req = 0.

Reset
REQ-034 SHALL, while Reset = 1, asynchronously force: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, ReadDataFromMem_MEM 0, AddrErr_MEM 0, BusErr_MEM 0, timeout counter 0.
REQ-035 SHALL, on Reset asserted mid-WAIT, abandon the outstanding access; a subsequent mem_ack is ignored.
REQ-036 SHALL keep Stall_MEM = 0 while Reset = 1.

Configuration
REQ-037 SHALL, with MEM_TIMEOUT_EN defined, count WAIT cycles; when the count reaches TIMEOUT_CYC with no ack, it SHALL drop mem_req, pulse BusErr_MEM, move to DONE, and leave read data unchanged.
REQ-038 SHALL, without MEM_TIMEOUT_EN, contain no counter, tie BusErr_MEM to 0, and wait in WAIT indefinitely.

Structure
REQ-039 SHALL place the MemSize encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and the FSM state encoding in shared package mem_pkg.
REQ-040 SHALL implement lane selection and extension in one sub-module, load_extend (purely combinational, 32-bit data + addr[1:0] + size + signed in, 32-bit out).

Verification
REQ-041 SHALL cover: word store to 0x0000_0010 of 0xDEADBEEF, ack on the 2nd WAIT cycle → mem_be 1111, mem_wdata DEADBEEF, Stall high for 3 cycles, then low for 1.
REQ-042 SHALL cover: signed byte load at 0x03, mem_rdata 0x80FF_FF7F → ReadDataFromMem_MEM = 0xFFFF_FF80; the same access unsigned → 0x0000_0080.
REQ-043 SHALL cover: half store 0x1234 at 0x06 → mem_be 1100, mem_wdata 0x1234_1234, mem_addr 0x04.
REQ-044 SHALL cover: word load at 0x02 → AddrErr_MEM one-cycle pulse, mem_req stays 0, Stall stays 0.
REQ-045 SHALL cover: Reset asserted in WAIT, then a stray mem_ack → all outputs 0, state IDLE, no data capture.
REQ-046 SHALL cover, with MEM_TIMEOUT_EN defined and TIMEOUT_CYC = 4, no ack: mem_req drops after 4 WAIT cycles, BusErr_MEM pulses once, and Stall is released.
